// File: rtl/encryption_init_pkg.sv
// Shared definitions for the key-exchange confirmation blocks (initiator and responder).
package encryption_init_pkg;

    localparam int CHAL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_CHECK
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_P0       = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_MISMATCH = 2'd3
    } err_t;

    // Challenge nibble: low bits of the shared key masked by a nonce.
    function automatic logic [CHAL_W-1:0] challenge(input logic [31:0] k, input logic [31:0] r);
        return k[CHAL_W-1:0] ^ r[CHAL_W-1:0];
    endfunction

endpackage

// File: rtl/encryption_init_if.sv
// Request/response signal bundle of the key-exchange initiator.
interface encryption_init_if;
    import encryption_init_pkg::*;

    logic              start;
    logic [63:0]       exp;
    logic [31:0]       p;
    logic [31:0]       r1;
    logic [31:0]       r2;
    logic [CHAL_W-1:0] c2;
    logic              c2_valid;
    logic [CHAL_W-1:0] c1;
    logic              c1_valid;
    logic              busy;
    logic              done;
    logic              true;
    logic [1:0]        err;

    modport master (
        output start, exp, p, r1, r2, c2, c2_valid,
        input  c1, c1_valid, busy, done, true, err
    );

    modport slave (
        input  start, exp, p, r1, r2, c2, c2_valid,
        output c1, c1_valid, busy, done, true, err
    );

endinterface

// File: rtl/mod_reduce_serial.sv
// Serial restoring reduction: rem = a mod m over 64 cycles, one dividend bit per cycle, MSB first.
module mod_reduce_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [31:0] m,
    output logic [31:0] rem,
    output logic        rdy
);

    logic [63:0] a_q;
    logic [31:0] m_q;
    logic [31:0] rem_q;
    logic [5:0]  idx;
    logic        active;

    // rem < m always holds, so the shifted value fits in 33 bits and one subtract restores it.
    function automatic logic [31:0] reduce_step(input logic [31:0] r, input logic b, input logic [31:0] mod);
        logic [32:0] r33;
        logic [32:0] diff;
        r33  = {r, b};
        diff = r33 - {1'b0, mod};
        return (r33 >= {1'b0, mod}) ? diff[31:0] : r33[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            m_q    <= '0;
            rem_q  <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            m_q    <= m;
            rem_q  <= '0;
            idx    <= 6'd63;
            active <= 1'b1;
        end else if (active) begin
            rem_q <= reduce_step(rem_q, a_q[idx], m_q);
            if (idx == 6'd0)
                active <= 1'b0;
            else
                idx <= idx - 6'd1;
        end
    end

    // High during the final step; rem carries the result from the next cycle on.
    assign rdy = active && (idx == 6'd0);
    assign rem = rem_q;

endmodule

// File: rtl/encryption_init.sv
// Key-exchange initiator: reduces the shared secret mod p, sends a challenge, checks the peer reply.
module encryption_init
    import encryption_init_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    encryption_init_if.slave    bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [31:0]       r1_q;
    logic [31:0]       r2_q;
    logic [CHAL_W-1:0] c1_q;
    logic [CHAL_W-1:0] c2_q;
    logic [CNT_W-1:0]  cnt;
    logic              true_q;
    err_t              err_q;
    logic              red_start;
    logic              red_rdy;
    logic [31:0]       k;
    logic [CHAL_W-1:0] c1_send;

    mod_reduce_serial u_reduce (
        .clk   (clk),
        .rst   (rst),
        .start (red_start),
        .a     (bus.exp),
        .m     (bus.p),
        .rem   (k),
        .rdy   (red_rdy)
    );

    assign c1_send = challenge(k, r2_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        red_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.p == '0) begin
                        state_nx = ST_CHECK;
                    end else begin
                        state_nx  = ST_REDUCE;
                        red_start = 1'b1;
                    end
                end
            end
            ST_REDUCE:    if (red_rdy) state_nx = ST_SEND;
            ST_SEND:      state_nx = ST_WAIT_RESP;
            // A response arriving on the last allowed cycle still wins over the timeout.
            ST_WAIT_RESP: if (bus.c2_valid || cnt == CNT_LAST) state_nx = ST_CHECK;
            ST_CHECK:     state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_q   <= '0;
            r2_q   <= '0;
            c1_q   <= 4'hF;
            c2_q   <= '0;
            cnt    <= '0;
            true_q <= 1'b0;
            err_q  <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r1_q   <= bus.r1;
                        r2_q   <= bus.r2;
                        c2_q   <= '0;
                        true_q <= 1'b0;
                        err_q  <= (bus.p == '0) ? ERR_P0 : ERR_NONE;
                    end
                end
                ST_SEND: begin
                    c1_q <= c1_send;
                    cnt  <= '0;
                end
                ST_WAIT_RESP: begin
                    if (bus.c2_valid)
                        c2_q <= bus.c2;
                    else if (cnt == CNT_LAST)
                        err_q <= ERR_TIMEOUT;
                    else
                        cnt <= cnt + 1'b1;
                end
                ST_CHECK: begin
                    if (err_q == ERR_NONE) begin
                        if (c2_q == challenge(k, r1_q))
                            true_q <= 1'b1;
                        else
                            err_q <= ERR_MISMATCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only the challenge nibble of the key and nonces takes part in the exchange.
    logic unused_bits;
    assign unused_bits = ^{k[31:CHAL_W], r1_q[31:CHAL_W], r2_q[31:CHAL_W]};

    assign bus.c1       = (state == ST_SEND) ? c1_send : c1_q;
    assign bus.c1_valid = (state == ST_SEND);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_CHECK);
    assign bus.true     = true_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_encryption_init.sv
// Self-checking bench for encryption_init: directed vector table, reset abort, randomized model check.
module tb_encryption_init;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic [63:0] e;
        logic [31:0] p;
        logic [31:0] r1;
        logic [31:0] r2;
        int          c2_at;   // WAIT_RESP cycle (1-based) carrying c2_valid; 0 = never
        logic [3:0]  c2;
        logic [3:0]  c1;
        logic        tr;
        logic [1:0]  er;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] last_c1;

    encryption_init_if bus();

    encryption_init #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: plain modular arithmetic and the verdict rules.
    function automatic vec_t model(input vec_t v);
        vec_t       o;
        logic [63:0] k;
        o = v;
        o.tr = 1'b0;
        if (v.p == 0) begin
            o.c1 = 4'h0;
            o.er = 2'd1;
        end else begin
            k    = v.e % {32'h0, v.p};
            o.c1 = k[3:0] ^ v.r2[3:0];
            if (v.c2_at == 0)
                o.er = 2'd2;
            else if (v.c2 == (k[3:0] ^ v.r1[3:0])) begin
                o.tr = 1'b1;
                o.er = 2'd0;
            end else
                o.er = 2'd3;
        end
        return o;
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int         n;
        int         c1v_cnt;
        int         c1v_n;
        logic [3:0] c1_seen;
        int         done_cnt;
        int         done_n;
        int         busy_bad;
        int         done_exp;
        c1v_cnt  = 0;
        c1v_n    = -1;
        c1_seen  = 4'h0;
        done_cnt = 0;
        done_n   = -1;
        busy_bad = 0;
        done_exp = (v.p == 0) ? 1 : 66 + ((v.c2_at > 0) ? v.c2_at : TIMEOUT);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.exp      = v.e;
        bus.p        = v.p;
        bus.r1       = v.r1;
        bus.r2       = v.r2;
        bus.c2_valid = 1'b0;
        n = 0;
        while (n < done_exp + 1) begin
            @(negedge clk);
            n++;
            if (bus.c1_valid === 1'b1) begin
                c1v_cnt++;
                c1v_n   = n;
                c1_seen = bus.c1;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_n = n;
            end
            if (n <= done_exp && bus.busy !== 1'b1) busy_bad++;
            // A stray start mid-transaction with p=0 would end it early if it were honoured.
            bus.start    = (n == 20);
            bus.p        = (n == 20) ? 32'h0 : v.p;
            bus.c2_valid = 1'b0;
            bus.c2       = 4'($urandom);
            if (v.c2_at > 0 && n == 65 + v.c2_at) begin
                bus.c2_valid = 1'b1;
                bus.c2       = v.c2;
            end else if (n >= 2 && n < 65 && n % 7 == 0) begin
                bus.c2_valid = 1'b1;
                bus.c2       = v.c2 ^ 4'h5;
            end
        end
        bus.start    = 1'b0;
        bus.c2_valid = 1'b0;
        check({nm, "_c1valid_count"}, c1v_cnt, (v.p == 0) ? 0 : 1);
        if (v.p != 0) begin
            check({nm, "_c1valid_cycle"}, c1v_n + 1, 66);
            check({nm, "_c1"}, c1_seen, v.c1);
        end
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_done_cycle"}, done_n, done_exp);
        check({nm, "_busy_gaps"}, busy_bad, 0);
        check({nm, "_busy_after"}, bus.busy, 1'b0);
        check({nm, "_true"}, bus.true, v.tr);
        check({nm, "_err"}, bus.err, v.er);
        check({nm, "_c1_held"}, bus.c1, (v.p == 0) ? last_c1 : v.c1);
        if (v.p != 0) last_c1 = v.c1;
    endtask

    task automatic late_c2_check(input vec_t v, input string nm);
        @(negedge clk);
        bus.c2_valid = 1'b1;
        bus.c2       = v.c1 ^ v.r2[3:0] ^ v.r1[3:0];
        @(negedge clk);
        bus.c2_valid = 1'b0;
        check({nm, "_late_err"}, bus.err, v.er);
        check({nm, "_late_true"}, bus.true, 1'b0);
        check({nm, "_late_busy"}, bus.busy, 1'b0);
        check({nm, "_late_done"}, bus.done, 1'b0);
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   dcnt;
    int   bcnt;

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.exp      = '0;
        bus.p        = '0;
        bus.r1       = '0;
        bus.r2       = '0;
        bus.c2       = '0;
        bus.c2_valid = 1'b0;
        last_c1      = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_c1", bus.c1, 4'hF);
        check("rst_c1_valid", bus.c1_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_true", bus.true, 1'b0);
        check("rst_err", bus.err, 2'd0);
        rst = 1'b1;

        //          exp                     p             r1     r2     c2_at c2    c1    tr    er
        tbl[0] = '{64'd100,                32'd7,        32'd9, 32'd5, 3,    4'hB, 4'h7, 1'b1, 2'd0};
        tbl[1] = '{64'd100,                32'd7,        32'd9, 32'd5, 3,    4'h0, 4'h7, 1'b0, 2'd3};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hA, 1,    4'h0, 4'hA, 1'b1, 2'd0};
        tbl[3] = '{64'd100,                32'd0,        32'd9, 32'd5, 2,    4'hB, 4'h0, 1'b0, 2'd1};
        tbl[4] = '{64'd100,                32'd7,        32'd9, 32'd5, 0,    4'hB, 4'h7, 1'b0, 2'd2};
        tbl[5] = '{64'd100,                32'd7,        32'd9, 32'd5, 16,   4'hB, 4'h7, 1'b1, 2'd0};
        tbl[6] = '{64'd1000,               32'd13,       32'd6, 32'd3, 1,    4'hA, 4'hF, 1'b1, 2'd0};
        tbl[7] = '{64'h1_2345_6789,        32'd1,        32'd2, 32'd4, 5,    4'h2, 4'h4, 1'b1, 2'd0};

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].er == 2'd2) late_c2_check(tbl[i], $sformatf("vec%0d", i));
        end

        // Abort in REDUCE cycle 30 with an asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1;
        bus.exp   = tbl[0].e;
        bus.p     = tbl[0].p;
        bus.r1    = tbl[0].r1;
        bus.r2    = tbl[0].r2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort_c1", bus.c1, 4'hF);
        check("abort_c1_valid", bus.c1_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_true", bus.true, 1'b0);
        check("abort_err", bus.err, 2'd0);
        @(negedge clk);
        rst  = 1'b1;
        dcnt = 0;
        bcnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done !== 1'b0) dcnt++;
            if (bus.busy !== 1'b0) bcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_stays_idle", bcnt, 0);
        last_c1 = 4'hF;
        run_txn(tbl[0], "after_rst");

        for (int i = 0; i < 24; i++) begin
            rv.e  = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       rv.p = 32'h0;
                1, 2, 3: rv.p = $urandom_range(1, 20);
                4:       rv.p = 32'hFFFF_FFFF;
                default: rv.p = $urandom;
            endcase
            rv.r1    = $urandom;
            rv.r2    = $urandom;
            rv.c2_at = $urandom_range(1, TIMEOUT + 3);
            if (rv.c2_at > TIMEOUT) rv.c2_at = 0;
            rv.c2    = 4'($urandom);
            if ($urandom_range(0, 2) != 0 && rv.p != 0)
                rv.c2 = 4'(rv.e % {32'h0, rv.p}) ^ rv.r1[3:0];
            rv = model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
